// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter in front of a shared single-port memory.
// Registered request, one-cycle completion pulses, wait-cycle timeout abort.
`timescale 1ns/1ps

module mem_arbiter #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned ARB_MODE = 0,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            imem_req,
    input  logic [XLEN-1:0] imem_addr,
    output logic [XLEN-1:0] imem_rdata,
    output logic            imem_valid,
    input  logic            dmem_req,
    input  logic            dmem_we,
    input  logic [XLEN-1:0] dmem_addr,
    input  logic [XLEN-1:0] dmem_wdata,
    output logic [XLEN-1:0] dmem_rdata,
    output logic            dmem_valid,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_ready,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            stall,
    output logic            bus_err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_BUSY = 2'd1,
        D_BUSY = 2'd2
    } state_t;

    localparam logic [15:0] WAIT_LIMIT = 16'(TIMEOUT - 2);

    state_t            state_q, state_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [XLEN-1:0]   mem_addr_q, mem_addr_d;
    logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;
    logic [XLEN-1:0]   imem_rdata_q, imem_rdata_d;
    logic              imem_valid_q, imem_valid_d;
    logic [XLEN-1:0]   dmem_rdata_q, dmem_rdata_d;
    logic              dmem_valid_q, dmem_valid_d;
    logic              bus_err_q, bus_err_d;
    logic [15:0]       wait_q, wait_d;
    logic              last_data_q, last_data_d;

    logic              busy;
    logic              done;
    logic              abort;
    logic              cand_i;
    logic              cand_d;
    logic              grant_i;
    logic              grant_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            imem_rdata_q <= '0;
            imem_valid_q <= 1'b0;
            dmem_rdata_q <= '0;
            dmem_valid_q <= 1'b0;
            bus_err_q    <= 1'b0;
            wait_q       <= '0;
            last_data_q  <= 1'b1;
        end else begin
            state_q      <= state_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            imem_rdata_q <= imem_rdata_d;
            imem_valid_q <= imem_valid_d;
            dmem_rdata_q <= dmem_rdata_d;
            dmem_valid_q <= dmem_valid_d;
            bus_err_q    <= bus_err_d;
            wait_q       <= wait_d;
            last_data_q  <= last_data_d;
        end
    end

    // A request whose valid is pulsing this cycle has already been served;
    // the port just completing is likewise excluded from re-arbitration.
    always_comb begin
        busy    = (state_q != IDLE);
        done    = busy & mem_req_q & mem_ready;
        abort   = busy & mem_req_q & ~mem_ready & (wait_q == WAIT_LIMIT);
        cand_i  = imem_req & ~imem_valid_q & ~(done & (state_q == I_BUSY));
        cand_d  = dmem_req & ~dmem_valid_q & ~(done & (state_q == D_BUSY));
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (!busy || done) begin
            if (cand_i && cand_d) begin
                if (ARB_MODE == 0) begin
                    grant_d = 1'b1;
                end else if (last_data_q) begin
                    grant_i = 1'b1;
                end else begin
                    grant_d = 1'b1;
                end
            end else begin
                grant_i = cand_i;
                grant_d = cand_d;
            end
        end
        state_d = state_q;
        if (grant_i) begin
            state_d = I_BUSY;
        end else if (grant_d) begin
            state_d = D_BUSY;
        end else if (done || abort) begin
            state_d = IDLE;
        end
    end

    always_comb begin
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        imem_rdata_d = imem_rdata_q;
        dmem_rdata_d = dmem_rdata_q;
        imem_valid_d = 1'b0;
        dmem_valid_d = 1'b0;
        bus_err_d    = 1'b0;
        wait_d       = wait_q;
        last_data_d  = last_data_q;

        if (done) begin
            mem_req_d = 1'b0;
            if (state_q == I_BUSY) begin
                imem_valid_d = 1'b1;
                imem_rdata_d = mem_rdata;
            end else begin
                dmem_valid_d = 1'b1;
                if (!mem_we_q) begin
                    dmem_rdata_d = mem_rdata;
                end
            end
        end else if (abort) begin
            mem_req_d = 1'b0;
            bus_err_d = 1'b1;
            if (state_q == I_BUSY) begin
                imem_valid_d = 1'b1;
                imem_rdata_d = '0;
            end else begin
                dmem_valid_d = 1'b1;
                dmem_rdata_d = '0;
            end
        end else if (busy) begin
            wait_d = wait_q + 16'd1;
        end

        // A grant in the completion cycle overrides the mem_req clear above.
        if (grant_i) begin
            mem_req_d   = 1'b1;
            mem_we_d    = 1'b0;
            mem_addr_d  = imem_addr;
            mem_wdata_d = '0;
            wait_d      = '0;
            last_data_d = 1'b0;
        end else if (grant_d) begin
            mem_req_d   = 1'b1;
            mem_we_d    = dmem_we;
            mem_addr_d  = dmem_addr;
            mem_wdata_d = dmem_wdata;
            wait_d      = '0;
            last_data_d = 1'b1;
        end
    end

    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign imem_rdata = imem_rdata_q;
    assign imem_valid = imem_valid_q;
    assign dmem_rdata = dmem_rdata_q;
    assign dmem_valid = dmem_valid_q;
    assign bus_err    = bus_err_q;
    assign stall      = (imem_req & ~imem_valid_q) | (dmem_req & ~dmem_valid_q);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench: dut0 is fixed-priority with a short timeout,
// dut1 is round-robin; both share the stimulus inputs.
`timescale 1ns/1ps

module tb_mem_arbiter;

    localparam int unsigned XLEN = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            dmem_req;
    logic            dmem_we;
    logic [XLEN-1:0] dmem_addr;
    logic [XLEN-1:0] dmem_wdata;
    logic            mem_ready;
    logic [XLEN-1:0] mem_rdata;

    logic [XLEN-1:0] imem_rdata0, dmem_rdata0, mem_addr0, mem_wdata0;
    logic            imem_valid0, dmem_valid0, mem_req0, mem_we0, stall0, bus_err0;
    logic [XLEN-1:0] imem_rdata1, dmem_rdata1, mem_addr1, mem_wdata1;
    logic            imem_valid1, dmem_valid1, mem_req1, mem_we1, stall1, bus_err1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.XLEN(XLEN), .ARB_MODE(0), .TIMEOUT(4)) dut0 (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata0), .imem_valid(imem_valid0),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata0), .dmem_valid(dmem_valid0),
        .mem_req(mem_req0), .mem_we(mem_we0), .mem_addr(mem_addr0), .mem_wdata(mem_wdata0),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .stall(stall0), .bus_err(bus_err0)
    );

    mem_arbiter #(.XLEN(XLEN), .ARB_MODE(1), .TIMEOUT(255)) dut1 (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata1), .imem_valid(imem_valid1),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata1), .dmem_valid(dmem_valid1),
        .mem_req(mem_req1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .stall(stall1), .bus_err(bus_err1)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        imem_req   = 1'b0;
        imem_addr  = '0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        dmem_addr  = '0;
        dmem_wdata = '0;
        mem_ready  = 1'b0;
        mem_rdata  = '0;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        reset = 1'b0;
        #1;
        if ({mem_req0, mem_we0, imem_valid0, dmem_valid0, bus_err0, stall0} !== 6'b0) begin
            errors++; $display("FAIL rst_ctrl: got %b exp 000000",
                {mem_req0, mem_we0, imem_valid0, dmem_valid0, bus_err0, stall0});
        end
        checks++;
        if ({mem_addr0, mem_wdata0, imem_rdata0, dmem_rdata0} !== 128'h0) begin
            errors++; $display("FAIL rst_data: got %h exp 0",
                {mem_addr0, mem_wdata0, imem_rdata0, dmem_rdata0});
        end
        checks++;
        imem_req = 1'b1;
        #1;
        if (stall0 !== 1'b1) begin
            errors++; $display("FAIL rst_stall: got %b exp 1", stall0);
        end
        checks++;
        imem_req  = 1'b0;
        reset     = 1'b1;
        mem_ready = 1'b1;
        step();
        step();
        if ({mem_req0, imem_valid0, dmem_valid0} !== 3'b000) begin
            errors++; $display("FAIL idle_ready_ignored: got %b exp 000",
                {mem_req0, imem_valid0, dmem_valid0});
        end
        checks++;
    endtask

    task automatic test_fetch();
        apply_reset();
        imem_req  = 1'b1;
        imem_addr = 32'h200;
        mem_ready = 1'b1;
        mem_rdata = 32'h13;
        step();
        if ({mem_req0, mem_we0, imem_valid0, stall0} !== 4'b1001 || mem_addr0 !== 32'h200) begin
            errors++; $display("FAIL fetch_issue: got req/we/val/stall=%b addr=%h exp 1001 addr=200",
                {mem_req0, mem_we0, imem_valid0, stall0}, mem_addr0);
        end
        checks++;
        step();
        if (imem_valid0 !== 1'b1 || imem_rdata0 !== 32'h13) begin
            errors++; $display("FAIL fetch_done: got valid=%b rdata=%h exp 1 00000013",
                imem_valid0, imem_rdata0);
        end
        checks++;
        if (mem_req0 !== 1'b0 || stall0 !== 1'b0) begin
            errors++; $display("FAIL fetch_release: got req=%b stall=%b exp 0 0", mem_req0, stall0);
        end
        checks++;
        imem_req = 1'b0;
        step();
        if (imem_valid0 !== 1'b0 || mem_req0 !== 1'b0) begin
            errors++; $display("FAIL fetch_pulse_len: got valid=%b req=%b exp 0 0", imem_valid0, mem_req0);
        end
        checks++;
    endtask

    task automatic test_contention_fixed();
        apply_reset();
        imem_req   = 1'b1;
        imem_addr  = 32'h300;
        dmem_req   = 1'b1;
        dmem_we    = 1'b1;
        dmem_addr  = 32'h1000;
        dmem_wdata = 32'hDEADBEEF;
        mem_ready  = 1'b1;
        mem_rdata  = 32'h55;
        step();
        if (mem_req0 !== 1'b1 || mem_we0 !== 1'b1 || mem_addr0 !== 32'h1000 || mem_wdata0 !== 32'hDEADBEEF) begin
            errors++; $display("FAIL fixed_store_first: got req=%b we=%b addr=%h wdata=%h exp 1 1 1000 deadbeef",
                mem_req0, mem_we0, mem_addr0, mem_wdata0);
        end
        checks++;
        if (mem_addr1 !== 32'h300) begin
            errors++; $display("FAIL rr_first_fetch: got addr=%h exp 300", mem_addr1);
        end
        checks++;
        step();
        if (dmem_valid0 !== 1'b1 || imem_valid0 !== 1'b0 || dmem_rdata0 !== 32'h0) begin
            errors++; $display("FAIL fixed_store_done: got dval=%b ival=%b drdata=%h exp 1 0 0",
                dmem_valid0, imem_valid0, dmem_rdata0);
        end
        checks++;
        if (mem_req0 !== 1'b1 || mem_we0 !== 1'b0 || mem_addr0 !== 32'h300) begin
            errors++; $display("FAIL fixed_b2b_fetch: got req=%b we=%b addr=%h exp 1 0 300",
                mem_req0, mem_we0, mem_addr0);
        end
        checks++;
        dmem_req = 1'b0;
        step();
        if (imem_valid0 !== 1'b1 || dmem_valid0 !== 1'b0 || imem_rdata0 !== 32'h55 || mem_req0 !== 1'b0) begin
            errors++; $display("FAIL fixed_fetch_done: got ival=%b dval=%b irdata=%h req=%b exp 1 0 55 0",
                imem_valid0, dmem_valid0, imem_rdata0, mem_req0);
        end
        checks++;
        imem_req = 1'b0;
        step();
    endtask

    task automatic test_round_robin();
        logic [5:0] seq;
        int         n;
        logic       got_i;
        logic       got_d;
        apply_reset();
        seq       = '0;
        n         = 0;
        mem_ready = 1'b1;
        mem_rdata = 32'h1;
        for (int r = 0; r < 3; r++) begin
            imem_req  = 1'b1;
            imem_addr = 32'h400 + 32'(r * 16);
            dmem_req  = 1'b1;
            dmem_we   = 1'b0;
            dmem_addr = 32'h800 + 32'(r * 16);
            got_i     = 1'b0;
            got_d     = 1'b0;
            for (int c = 0; c < 8 && !(got_i && got_d); c++) begin
                step();
                if (imem_valid1 && !got_i) begin
                    if (n < 6) seq[n] = 1'b0;
                    n++; got_i = 1'b1; imem_req = 1'b0;
                end
                if (dmem_valid1 && !got_d) begin
                    if (n < 6) seq[n] = 1'b1;
                    n++; got_d = 1'b1; dmem_req = 1'b0;
                end
            end
            if (!(got_i && got_d)) begin
                errors++; $display("FAIL rr_round%0d_timeout: got i=%b d=%b exp 1 1", r, got_i, got_d);
            end
            checks++;
            step();
        end
        if (seq[2:0] !== 3'b010) begin
            errors++; $display("FAIL rr_order_IDI: got %b (bit0 first, 1=D) exp 010", seq[2:0]);
        end
        checks++;
        if (n !== 6 || seq !== 6'b101010) begin
            errors++; $display("FAIL rr_full_order: got n=%0d seq=%b exp 6 101010", n, seq);
        end
        checks++;
    endtask

    task automatic test_timeout();
        apply_reset();
        mem_ready = 1'b1;
        mem_rdata = 32'hA5A5A5A5;
        dmem_req  = 1'b1;
        dmem_addr = 32'h40;
        step();
        step();
        if (dmem_valid0 !== 1'b1 || dmem_rdata0 !== 32'hA5A5A5A5) begin
            errors++; $display("FAIL pre_load: got val=%b rdata=%h exp 1 a5a5a5a5", dmem_valid0, dmem_rdata0);
        end
        checks++;
        dmem_req  = 1'b0;
        mem_ready = 1'b0;
        step();
        dmem_req  = 1'b1;
        dmem_addr = 32'h44;
        step();
        if (mem_req0 !== 1'b1 || mem_addr0 !== 32'h44) begin
            errors++; $display("FAIL to_issue: got req=%b addr=%h exp 1 44", mem_req0, mem_addr0);
        end
        checks++;
        step();
        step();
        if (dmem_valid0 !== 1'b0 || bus_err0 !== 1'b0 || mem_req0 !== 1'b1 || mem_addr0 !== 32'h44) begin
            errors++; $display("FAIL to_waiting: got val=%b err=%b req=%b addr=%h exp 0 0 1 44",
                dmem_valid0, bus_err0, mem_req0, mem_addr0);
        end
        checks++;
        step();
        if (dmem_valid0 !== 1'b1 || bus_err0 !== 1'b1 || dmem_rdata0 !== 32'h0 || mem_req0 !== 1'b0) begin
            errors++; $display("FAIL to_abort: got val=%b err=%b rdata=%h req=%b exp 1 1 0 0",
                dmem_valid0, bus_err0, dmem_rdata0, mem_req0);
        end
        checks++;
        dmem_req = 1'b0;
        step();
        if (dmem_valid0 !== 1'b0 || bus_err0 !== 1'b0 || mem_req0 !== 1'b0) begin
            errors++; $display("FAIL to_after: got val=%b err=%b req=%b exp 0 0 0", dmem_valid0, bus_err0, mem_req0);
        end
        checks++;
    endtask

    task automatic test_ready_at_timeout();
        apply_reset();
        dmem_req  = 1'b1;
        dmem_we   = 1'b0;
        dmem_addr = 32'h48;
        step();
        dmem_req = 1'b0;
        step();
        step();
        mem_ready = 1'b1;
        mem_rdata = 32'h77;
        step();
        if (dmem_valid0 !== 1'b1 || bus_err0 !== 1'b0 || dmem_rdata0 !== 32'h77) begin
            errors++; $display("FAIL ready_at_limit: got val=%b err=%b rdata=%h exp 1 0 77",
                dmem_valid0, bus_err0, dmem_rdata0);
        end
        checks++;
        mem_ready = 1'b0;
        step();
        if (dmem_valid0 !== 1'b0 || mem_req0 !== 1'b0) begin
            errors++; $display("FAIL ready_at_limit_after: got val=%b req=%b exp 0 0", dmem_valid0, mem_req0);
        end
        checks++;
    endtask

    task automatic test_reset_mid_transaction();
        apply_reset();
        dmem_req   = 1'b1;
        dmem_we    = 1'b1;
        dmem_addr  = 32'h80;
        dmem_wdata = 32'h1234;
        step();
        step();
        if (mem_req0 !== 1'b1 || mem_we0 !== 1'b1) begin
            errors++; $display("FAIL mid_busy: got req=%b we=%b exp 1 1", mem_req0, mem_we0);
        end
        checks++;
        reset = 1'b0;
        #1;
        if ({mem_req0, mem_we0, dmem_valid0, bus_err0} !== 4'b0 || mem_addr0 !== 32'h0 || mem_wdata0 !== 32'h0) begin
            errors++; $display("FAIL mid_async_clear: got ctl=%b addr=%h wdata=%h exp 0000 0 0",
                {mem_req0, mem_we0, dmem_valid0, bus_err0}, mem_addr0, mem_wdata0);
        end
        checks++;
        if (stall0 !== 1'b1) begin
            errors++; $display("FAIL mid_stall: got %b exp 1", stall0);
        end
        checks++;
        @(negedge clk);
        reset = 1'b1;
        step();
        if (mem_req0 !== 1'b1 || mem_addr0 !== 32'h80 || dmem_valid0 !== 1'b0) begin
            errors++; $display("FAIL mid_regrant: got req=%b addr=%h val=%b exp 1 80 0",
                mem_req0, mem_addr0, dmem_valid0);
        end
        checks++;
        mem_ready = 1'b1;
        step();
        if (dmem_valid0 !== 1'b1 || bus_err0 !== 1'b0) begin
            errors++; $display("FAIL mid_complete: got val=%b err=%b exp 1 0", dmem_valid0, bus_err0);
        end
        checks++;
        dmem_req  = 1'b0;
        mem_ready = 1'b0;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_fetch();
        test_contention_fixed();
        test_round_robin();
        test_timeout();
        test_ready_at_timeout();
        test_reset_mid_transaction();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter XLEN, default 32: width of addresses and data words.
REQ-002 Parameter ARB_MODE, default 0: 0 = fixed data priority; 1 = round-robin between the two requesters.
REQ-003 Parameter TIMEOUT, default 255: maximum wait cycles for mem_ready before a transaction aborts; legal range 2..65535.
REQ-004 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1: asynchronous, active-low reset.
REQ-006 Port imem_req, input, 1: instruction fetch request, held high until imem_valid.
REQ-007 Port imem_addr, input, XLEN: fetch address, stable while imem_req is high.
REQ-008 Port imem_rdata, output, XLEN: registered fetch data.
REQ-009 Port imem_valid, output, 1: one-cycle completion pulse for the fetch.
REQ-010 Port dmem_req, input, 1: data access request, held high until dmem_valid.
REQ-011 Port dmem_we, input, 1: 1 = store, 0 = load.
REQ-012 Port dmem_addr, input, XLEN: data address, stable while dmem_req is high.
REQ-013 Port dmem_wdata, input, XLEN: store data, stable while dmem_req is high.
REQ-014 Port dmem_rdata, output, XLEN: registered load data.
REQ-015 Port dmem_valid, output, 1: one-cycle completion pulse for the data access.
REQ-016 Port mem_req/mem_we/mem_addr/mem_wdata, output, 1/1/XLEN/XLEN: registered request to the shared single-port memory.
REQ-017 Port mem_ready, input, 1: memory completes the current request in this cycle.
REQ-018 Port mem_rdata, input, XLEN: memory read data, valid when mem_ready is high.
REQ-019 Port stall, output, 1: datapath hold, combinational.
REQ-020 Port bus_err, output, 1: one-cycle pulse when a transaction aborts on timeout.

Function
REQ-021 The FSM SHALL have three states: IDLE, I_BUSY and D_BUSY.
REQ-022 IDLE SHALL grant to the single requester when only one is asserted, and SHALL stay in IDLE when neither is asserted.
REQ-023 IDLE with both requests asserted SHALL grant as follows: ARB_MODE=0 grants data; ARB_MODE=1 grants the port not granted last.
REQ-024 On a grant, the arbiter SHALL register addr, we (0 for fetch) and wdata into mem_*, and SHALL drive mem_req=1 from the next cycle.
REQ-025 In a BUSY state, mem_req/mem_we/mem_addr/mem_wdata SHALL hold constant until mem_ready or timeout.
REQ-026 When mem_ready=1 in BUSY, the arbiter SHALL, on the next cycle, pulse the owner's valid for 1 cycle, load the owner's rdata from mem_rdata (loads and fetches only; stores leave dmem_rdata unchanged), and clear mem_req unless a new grant is issued.
REQ-027 In the completion cycle, arbitration SHALL be re-evaluated excluding the port just served, so the next transaction issues back-to-back; with no eligible requester the FSM SHALL return to IDLE.
REQ-028 Minimum latency, request to valid, SHALL be 2 cycles (grant, then mem_ready in the first BUSY cycle).
REQ-029 The wait counter SHALL clear on each grant and increment each BUSY cycle without mem_ready.
REQ-030 When the wait counter reaches TIMEOUT-1 without mem_ready, the arbiter SHALL abort the transaction: owner valid and bus_err pulse together, owner rdata loaded with 0, mem_req dropped for at least one cycle, and the FSM returns to IDLE.
REQ-031 mem_ready arriving in the same cycle as the timeout SHALL count as normal completion with no bus_err.
REQ-032 mem_ready while mem_req=0 SHALL be ignored.
REQ-033 stall SHALL equal (imem_req & ~imem_valid) | (dmem_req & ~dmem_valid).
REQ-034 The round-robin last-grant bit SHALL update only on grants, never on aborts or idle cycles.
REQ-035 A requester dropping its req mid-transaction SHALL NOT cancel the transaction; it completes and its valid still pulses.

Reset
REQ-036 Asserting reset (low) SHALL asynchronously force state IDLE, all outputs except stall to 0, the wait counter to 0, and last-grant to data.
REQ-037 A transaction in flight when reset asserts SHALL be discarded, with no valid pulse after reset is released.
REQ-038 The first edge after reset is released SHALL perform normal IDLE arbitration.

Verification
REQ-039 Fetch only: imem_req=1, addr=0x200, mem_ready high in the first BUSY cycle, rdata=0x00000013 -> mem_addr=0x200, we=0; imem_valid two cycles after the request with imem_rdata=0x13.
REQ-040 Contention, ARB_MODE=0: both requests, dmem store addr=0x1000, wdata=0xDEADBEEF -> store issues first; fetch issues in the completion cycle (back-to-back); dmem_valid precedes imem_valid.
REQ-041 Contention, ARB_MODE=1 with three consecutive both-request rounds -> grant order I, D, I.
REQ-042 Timeout: TIMEOUT=4, mem_ready held low -> abort after 3 wait cycles; dmem_valid=1, bus_err=1, dmem_rdata=0; mem_req=0 the following cycle.
REQ-043 Reset mid-transaction: reset low during D_BUSY -> all outputs 0 immediately; after release, the pending dmem_req is re-granted with no stale valid pulse.
